// File: rtl/ota_sar_ctrl.sv
// Successive-approximation controller for the OTA output: track/hold, binary-search
// the capacitive DAC code MSB first against a synchronized comparator, return the result.
module ota_sar_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SAMPLE_CYC = 4,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_MAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAMPLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             sync1_q, sync2_q;
    logic             cmp_s;
    logic [WIDTH-1:0] bit_mask;

    assign cmp_s    = sync2_q;
    assign bit_mask = WIDTH'(1) << idx_q;
    assign result   = result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            trial_q  <= '0;
            result_q <= '0;
        end else begin
            sync1_q  <= cmp_in;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            trial_q  <= trial_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        trial_d  = trial_q;
        result_d = result_q;
        sample   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        dac_code = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                    trial_d = '0;
                end
            end
            S_SAMPLE: begin
                sample = 1'b1;
                busy   = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == SAMPLE_LAST) begin
                    state_d = S_CONV;
                    cnt_d   = '0;
                    idx_d   = MSB_IDX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CONV: begin
                busy     = 1'b1;
                dac_code = trial_q | bit_mask;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    // Bit under trial is still clear in trial_q, so OR-ing keeps or drops it.
                    cnt_d   = '0;
                    trial_d = trial_q | (cmp_s ? bit_mask : '0);
                    if (idx_q == '0) begin
                        state_d  = S_DONE;
                        result_d = trial_q | (cmp_s ? bit_mask : '0);
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ota_sar_ctrl.sv
// Directed bench for ota_sar_ctrl: ideal comparator, per-cycle check against a
// cycle-position model, plus literal expectations for the documented scenarios.
module tb_ota_sar_ctrl;

    localparam int T_MAIN = 1 + 4 + 8 * 4;
    localparam int T_CORN = 1 + 1 + 4 * 3;

    logic       clk;
    logic       rst;
    logic       start, abort, cmp_in;
    logic       sample, busy, done;
    logic [7:0] dac_code, result;
    logic [7:0] vin;

    logic       c_start, c_abort, c_cmp_in;
    logic       c_sample, c_busy, c_done;
    logic [3:0] c_dac_code, c_result;
    logic [3:0] c_vin;

    int checks;
    int errors;
    int cyc;

    int mk, mres;
    int ck, cres;

    logic [7:0] dac_log [0:63];
    logic       busy_log[0:63];

    ota_sar_ctrl #(.WIDTH(8), .SAMPLE_CYC(4), .SETTLE_CYC(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cmp_in(cmp_in),
        .sample(sample), .dac_code(dac_code), .busy(busy), .done(done), .result(result)
    );

    ota_sar_ctrl #(.WIDTH(4), .SAMPLE_CYC(1), .SETTLE_CYC(3)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .abort(c_abort), .cmp_in(c_cmp_in),
        .sample(c_sample), .dac_code(c_dac_code), .busy(c_busy), .done(c_done), .result(c_result)
    );

    assign cmp_in   = (vin >= dac_code);
    assign c_cmp_in = (c_vin >= c_dac_code);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the position k inside a conversion (0 = idle). With an
    // ideal comparator the kept bits equal the input's bits above the trial bit.
    function automatic void model_out(input int k, input int v, input int w, input int sc,
                                      input int st, output int s, output int b,
                                      output int d, output int dac);
        int t, j, i;
        t = 1 + sc + w * st;
        s = 0; b = 0; d = 0; dac = 0;
        if (k >= 1 && k <= sc) begin
            s = 1; b = 1;
        end else if (k > sc && k < t) begin
            b   = 1;
            j   = (k - 1 - sc) / st;
            i   = w - 1 - j;
            dac = ((v >> (i + 1)) << (i + 1)) | (1 << i);
        end else if (k == t) begin
            d = 1;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mk <= 0; mres <= 0;
        end else if (mk >= 1 && mk < T_MAIN && abort) begin
            mk <= 0;
        end else if (mk >= 1 && mk < T_MAIN) begin
            mk <= mk + 1;
            if (mk + 1 == T_MAIN) mres <= int'(vin);
        end else if (mk == T_MAIN) begin
            mk <= 0;
        end else if (start) begin
            mk <= 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ck <= 0; cres <= 0;
        end else if (ck >= 1 && ck < T_CORN && c_abort) begin
            ck <= 0;
        end else if (ck >= 1 && ck < T_CORN) begin
            ck <= ck + 1;
            if (ck + 1 == T_CORN) cres <= int'(c_vin);
        end else if (ck == T_CORN) begin
            ck <= 0;
        end else if (c_start) begin
            ck <= 1;
        end
    end

    always @(negedge clk) begin
        int es, eb, ed, edac;
        if (!rst) begin
            model_out(mk, int'(vin), 8, 4, 4, es, eb, ed, edac);
            chk("sample", int'(sample), es);
            chk("busy", int'(busy), eb);
            chk("done", int'(done), ed);
            chk("dac_code", int'(dac_code), edac);
            chk("result", int'(result), mres);
            model_out(ck, int'(c_vin), 4, 1, 3, es, eb, ed, edac);
            chk("c_sample", int'(c_sample), es);
            chk("c_busy", int'(c_busy), eb);
            chk("c_done", int'(c_done), ed);
            chk("c_dac_code", int'(c_dac_code), edac);
            chk("c_result", int'(c_result), cres);
        end
    end

    task automatic pulse_start(input logic [7:0] v, output int e0);
        vin = v;
        @(negedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e0 = cyc;
    endtask

    task automatic run_conv(input logic [7:0] v, input int exp_res, input string tag);
        int e0, dcyc;
        dcyc = -1;
        pulse_start(v, e0);
        for (int n = 1; n <= 60 && dcyc < 0; n++) begin
            @(negedge clk);
            dac_log[n]  = dac_code;
            busy_log[n] = busy;
            if (done) begin
                dcyc = cyc - e0 + 1;
                chk({tag, "_result"}, int'(result), exp_res);
            end
        end
        chk({tag, "_done_cycle"}, dcyc, 37);
    endtask

    initial begin
        int e0, nd, ndone;
        int dcycs[0:2];
        int exp_seq[0:7];
        exp_seq = '{32'h80, 32'hC0, 32'hA0, 32'hB0, 32'hA8, 32'hA4, 32'hA6, 32'hA5};
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; vin = 8'h00;
        c_start = 1'b0; c_abort = 1'b0; c_vin = 4'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sample", int'(sample), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dac", int'(dac_code), 0);
        chk("rst_result", int'(result), 0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Mid-range code with the documented DAC trial sequence.
        run_conv(8'hA5, 32'hA5, "mid");
        for (int j = 0; j < 8; j++) begin
            chk("mid_dac_first", int'(dac_log[5 + 4 * j]), exp_seq[j]);
            chk("mid_dac_last", int'(dac_log[8 + 4 * j]), exp_seq[j]);
        end
        chk("mid_busy_c1", int'(busy_log[1]), 1);
        chk("mid_busy_c36", int'(busy_log[36]), 1);
        chk("mid_busy_c37", int'(busy_log[37]), 0);
        repeat (3) @(negedge clk);

        run_conv(8'h00, 32'h00, "zero");
        repeat (3) @(negedge clk);
        run_conv(8'hFF, 32'hFF, "full");
        repeat (3) @(negedge clk);

        // start held high: back-to-back conversions 38 cycles apart.
        vin = 8'h3C;
        @(negedge clk);
        #1 start = 1'b1;
        nd = 0;
        for (int n = 0; n < 200 && nd < 3; n++) begin
            @(negedge clk);
            if (done) begin
                dcycs[nd] = cyc;
                nd++;
                chk("b2b_result", int'(result), 32'h3C);
            end
        end
        #1 start = 1'b0;
        chk("b2b_count", nd, 3);
        if (nd == 3) begin
            chk("b2b_gap1", dcycs[1] - dcycs[0], 38);
            chk("b2b_gap2", dcycs[2] - dcycs[1], 38);
        end
        repeat (3) @(negedge clk);

        // Abort in cycle 10 of a second conversion.
        run_conv(8'h55, 32'h55, "pre_abort");
        repeat (2) @(negedge clk);
        pulse_start(8'hAA, e0);
        repeat (10) @(negedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy_c11", int'(busy), 0);
        chk("abort_sample_c11", int'(sample), 0);
        chk("abort_dac_c11", int'(dac_code), 0);
        ndone = 0;
        repeat (45) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_result", int'(result), 32'h55);

        // Asynchronous reset in the middle of CONV.
        pulse_start(8'h77, e0);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_sample", int'(sample), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_dac", int'(dac_code), 0);
        chk("arst_result", int'(result), 0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        run_conv(8'h77, 32'h77, "post_rst");
        repeat (3) @(negedge clk);

        // Parameter corner: WIDTH=4, SAMPLE_CYC=1, SETTLE_CYC=3.
        c_vin = 4'h9;
        @(negedge clk);
        #1 c_start = 1'b1;
        @(posedge clk);
        #1 c_start = 1'b0;
        e0 = cyc;
        nd = -1;
        for (int n = 1; n <= 30 && nd < 0; n++) begin
            @(negedge clk);
            if (c_done) begin
                nd = cyc - e0 + 1;
                chk("corner_result", int'(c_result), 32'h9);
            end
        end
        chk("corner_done_cycle", nd, 14);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ota_sar_ctrl.md
# ota_sar_ctrl

Successive-approximation controller that digitises the OTA output. It sits directly downstream of the OTA analog macro. It drives a track/hold switch and a binary-weighted capacitive DAC, reads back the analog comparator that follows the OTA, and returns a WIDTH-bit conversion result with a one-cycle completion pulse. It runs from the tile clock and fills the digital outputs that the OTA macro itself leaves tied low.

## Interface

Parameters:
- WIDTH, 8: result and DAC code width; legal range 2..12.
- SAMPLE_CYC, 4: number of cycles that track/hold stays in track; must be ≥1.
- SETTLE_CYC, 4: cycles per bit trial; must be ≥3 so that the 2-flop comparator synchronizer sees the new DAC code.

Ports:
- clk, input, 1: the single clock; all state updates on its rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- start, input, 1: request a conversion; sampled in IDLE only.
- abort, input, 1: synchronous cancel of a conversion in progress.
- cmp_in, input, 1: analog comparator output, asynchronous; 1 means Vota ≥ Vdac.
- sample, output, 1: track/hold control; 1 means track.
- dac_code, output, WIDTH: trial code driven to the capacitive DAC.
- busy, output, 1: high from SAMPLE through the last CONV cycle.
- done, output, 1: one-cycle pulse when result is updated.
- result, output, WIDTH: last completed conversion; held between conversions.

## Operation

- **Synchronizer.** cmp_in passes through a 2-flop synchronizer; all decisions use the second flop (cmp_s).
- **States:** IDLE, SAMPLE, CONV, DONE.
- **IDLE:** sample=0, busy=0, dac_code=0. If start=1 at an edge, go to SAMPLE and clear the trial register.
- **SAMPLE:** sample=1, busy=1, dac_code=0. Lasts exactly SAMPLE_CYC cycles, then go to CONV with bit index i=WIDTH-1.
- **CONV, per bit i (MSB first):**
  - On entry, dac_code = kept bits | (1<<i). It is held for SETTLE_CYC cycles.
  - At the edge ending the last settle cycle, bit i is kept if cmp_s=1 and cleared otherwise.
  - Then i decrements. After bit 0 resolves, go to DONE.
- **DONE:** exactly one cycle.
  - result is loaded with the final code (registered; visible in this cycle).
  - done=1, busy=0, sample=0, dac_code=0.
  - The next state is always IDLE.
- **start handling.** start is ignored in SAMPLE, CONV and DONE; it is not queued. A start held high through DONE begins a new conversion from IDLE on the following edge.
- **abort handling.** abort=1 at an edge in SAMPLE or CONV goes to IDLE next cycle. No done pulse is produced and result is unchanged. abort is ignored in IDLE and DONE. If abort and start arrive at the same edge in IDLE, start wins.
- **Arithmetic.** Unsigned only. No overflow is possible; each bit is set or cleared exactly once.

## Timing

- **Reset values.** On rst=1, all of the following are 0 immediately and asynchronously, with state=IDLE:
  - sample, busy, done, dac_code, result, trial register, both synchronizer flops.
- **Reset mid-conversion:** the conversion is lost, result=0, and there is no done pulse.
- **Latency.** Let edge 0 be the edge that samples start.
  - SAMPLE occupies cycles 1..SAMPLE_CYC.
  - CONV occupies the next WIDTH×SETTLE_CYC cycles.
  - done is high in cycle 1+SAMPLE_CYC+WIDTH×SETTLE_CYC. With default parameters that is cycle 37.
  - Minimum start-to-start period is that value +1.
- **Busy/done relation.** busy and done are never high in the same cycle. busy falls in the same cycle that done rises.
- **dac_code changes.** dac_code changes only at bit boundaries and state changes, never inside a settle window.

## Test plan

Comparator model used throughout: cmp_in = (VIN ≥ dac_code), combinational, with default parameters unless noted.

- **Mid-range code.** VIN=0xA5, start pulse.
  - dac_code sequence: 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5, each held for 4 cycles.
  - done in cycle 37 with result=0xA5; busy high in cycles 1..36.
- **Extremes.** VIN=0x00 gives result=0x00. VIN=0xFF gives result=0xFF. Both complete in 37 cycles with exactly one done pulse each.
- **Ignored start and back-to-back.** start is held high throughout with VIN=0x3C.
  - Every conversion yields result=0x3C.
  - done pulses are 38 cycles apart, with no extra conversions.
- **Abort.** Convert VIN=0x55 fully, then start with VIN=0xAA and assert abort in cycle 10.
  - State returns to IDLE in cycle 11.
  - There is no done pulse and result stays 0x55.
- **Async reset mid-conversion.** rst is pulsed mid-cycle during CONV.
  - All outputs drop to 0 without waiting for a clock edge, and result=0.
  - The next start converts normally.
- **Parameter corner.** WIDTH=4, SAMPLE_CYC=1, SETTLE_CYC=3 with VIN=0x9 gives result=0x9 and done in cycle 14.
